// File: rtl/glyph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | glyph_pkg                                                                  |
// | Shared FSM encoding, default geometry and row bit-reversal helper.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package glyph_pkg;

   localparam int DEF_GLYPH_W = 8;
   localparam int DEF_GLYPH_H = 8;
   localparam int DEF_ADDR_W  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [DEF_GLYPH_W-1:0] bit_reverse(input logic [DEF_GLYPH_W-1:0] v);
      logic [DEF_GLYPH_W-1:0] r;
      for (int i = 0; i < DEF_GLYPH_W; i++) begin
         r[i] = v[DEF_GLYPH_W-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rom_lat_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rom_lat_pipe                                                               |
// | Tag shift register that tracks which glyph row each ROM read belongs to.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rom_lat_pipe #(
   parameter int DEPTH = 1,
   parameter int TAG_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag
);

   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [TAG_W-1:0] tag_d [DEPTH];

   always_comb begin
      vld_d[0] = in_valid;
      tag_d[0] = in_tag;
      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_tag   = tag_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/glyph_row_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | glyph_row_fetcher                                                          |
// | Reads GLYPH_H consecutive ROM rows through one read port into a glyph bus. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module glyph_row_fetcher
   import glyph_pkg::*;
#(
   parameter int GLYPH_W     = DEF_GLYPH_W,
   parameter int GLYPH_H     = DEF_GLYPH_H,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int ROM_LATENCY = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic                       req_mirror,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [GLYPH_W-1:0]         rom_q,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [GLYPH_W*GLYPH_H-1:0] out_rows,
   output logic                       busy
);

   localparam int CNT_W = $clog2(GLYPH_H) + 1;

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          rom_addr_q, rom_addr_d;
   logic [CNT_W-1:0]           row_cnt_q, row_cnt_d;
   logic                       mirror_q, mirror_d;
   logic [GLYPH_W*GLYPH_H-1:0] rows_q, rows_d;

   logic                       last_row;
   logic                       fetch_active;
   logic                       tag_valid;
   logic [CNT_W-1:0]           tag_row;
   logic [GLYPH_W-1:0]         row_data;

   assign last_row     = (row_cnt_q == CNT_W'(GLYPH_H - 1));
   assign fetch_active = (state_q == ST_FETCH);

   // The tag enters alongside the address currently on rom_addr, so it exits
   // exactly when that address's data is on rom_q.
   rom_lat_pipe #(
      .DEPTH (ROM_LATENCY),
      .TAG_W (CNT_W)
   ) u_lat_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (fetch_active),
      .in_tag    (row_cnt_q),
      .out_valid (tag_valid),
      .out_tag   (tag_row)
   );

   generate
      if (GLYPH_W == DEF_GLYPH_W) begin : g_rev_pkg
         assign row_data = mirror_q ? bit_reverse(rom_q) : rom_q;
      end else begin : g_rev_loop
         always_comb begin
            for (int i = 0; i < GLYPH_W; i++) begin
               row_data[i] = mirror_q ? rom_q[GLYPH_W-1-i] : rom_q[i];
            end
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid) state_d = ST_FETCH;
         ST_FETCH: if (last_row) state_d = ST_DRAIN;
         ST_DRAIN: if (tag_valid && (tag_row == CNT_W'(GLYPH_H - 1))) state_d = ST_DONE;
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   end

   always_comb begin
      rom_addr_d = rom_addr_q;
      row_cnt_d  = row_cnt_q;
      mirror_d   = mirror_q;
      rows_d     = rows_q;
      if ((state_q == ST_IDLE) && req_valid) begin
         rom_addr_d = req_addr;
         mirror_d   = req_mirror;
         row_cnt_d  = '0;
      end else if (fetch_active && !last_row) begin
         rom_addr_d = rom_addr_q + ADDR_W'(1);
         row_cnt_d  = row_cnt_q + CNT_W'(1);
      end
      for (int r = 0; r < GLYPH_H; r++) begin
         if (tag_valid && (tag_row == CNT_W'(r))) begin
            rows_d[r*GLYPH_W +: GLYPH_W] = row_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rom_addr_q <= '0;
         row_cnt_q  <= '0;
         mirror_q   <= 1'b0;
         rows_q     <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         row_cnt_q  <= row_cnt_d;
         mirror_q   <= mirror_d;
         rows_q     <= rows_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign out_rows = rows_q;

endmodule
`default_nettype wire

// File: tb/tb_glyph_row_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_glyph_row_fetcher                                                       |
// | Two builds (8 rows/latency 1 and 16 rows/latency 2) against a glyph model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_glyph_row_fetcher;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         reset;
   logic         a_req_valid, a_req_ready, a_req_mirror, a_out_valid, a_out_ready, a_busy;
   logic [9:0]   a_req_addr, a_rom_addr;
   logic [7:0]   a_rom_q;
   logic [63:0]  a_out_rows;
   logic         b_req_valid, b_req_ready, b_req_mirror, b_out_valid, b_out_ready, b_busy;
   logic [9:0]   b_req_addr, b_rom_addr;
   logic [7:0]   b_rom_q, b_rom_p;
   logic [127:0] b_out_rows;

   glyph_row_fetcher #(.GLYPH_W(8), .GLYPH_H(8), .ADDR_W(10), .ROM_LATENCY(1)) u_dut_a (
      .clock(clock), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_addr(a_req_addr), .req_mirror(a_req_mirror), .rom_addr(a_rom_addr), .rom_q(a_rom_q),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_rows(a_out_rows), .busy(a_busy));

   glyph_row_fetcher #(.GLYPH_W(8), .GLYPH_H(16), .ADDR_W(10), .ROM_LATENCY(2)) u_dut_b (
      .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .req_mirror(b_req_mirror), .rom_addr(b_rom_addr), .rom_q(b_rom_q),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rows(b_out_rows), .busy(b_busy));

   logic [7:0] mem [1024];

   always @(posedge clock) begin
      a_rom_q <= mem[a_rom_addr];
      b_rom_p <= mem[b_rom_addr];
      b_rom_q <= b_rom_p;
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit chk_en = 0;

   // Glyph model: 0 = idle, 1 = request in flight (timed from acceptance cycle)
   int           m_mode [2];
   int           m_k [2];
   logic [9:0]   m_base [2];
   logic [9:0]   m_hold_addr [2];
   logic [127:0] m_exp [2];
   logic [127:0] m_last [2];

   logic [9:0] seen_addr [16];
   logic [9:0] wrap_exp [8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int geth(input int i);
      return (i == 0) ? 8 : 16;
   endfunction

   function automatic int getl(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   task automatic model_step(input int i, input logic rst, input logic rv, input logic [9:0] ra,
                             input logic mir, input logic ordy);
      int h = geth(i);
      int l = getl(i);
      logic [7:0] w, rw;
      if (rst) begin
         m_mode[i] = 0;
         m_last[i] = '0;
         m_hold_addr[i] = '0;
      end else if (m_mode[i] == 0) begin
         if (rv) begin
            m_mode[i] = 1;
            m_k[i] = cyc;
            m_base[i] = ra;
            m_exp[i] = '0;
            for (int r = 0; r < h; r++) begin
               w = mem[ra + 10'(r)];
               for (int b = 0; b < 8; b++) rw[b] = w[7-b];
               m_exp[i][r*8 +: 8] = mir ? rw : w;
            end
         end
      end else if ((cyc - m_k[i] > h + l) && ordy) begin
         m_mode[i] = 0;
         m_last[i] = m_exp[i];
         m_hold_addr[i] = m_base[i] + 10'(h - 1);
      end
   endtask

   task automatic check_inst(input int i, input logic rdy, input logic ov, input logic bsy,
                             input logic [9:0] ra, input logic [127:0] rows);
      int h = geth(i);
      int l = getl(i);
      int p;
      logic e_rdy, e_ov, e_bsy;
      logic [9:0] e_ra;
      logic [127:0] e_rows;
      bit do_rows;
      string pf = (i == 0) ? "a" : "b";
      e_rows = m_last[i];
      if (m_mode[i] == 0) begin
         e_rdy = 1; e_ov = 0; e_bsy = 0; e_ra = m_hold_addr[i]; do_rows = 1;
      end else begin
         p = cyc - m_k[i];
         e_rdy = 0;
         if (p <= h) begin
            e_bsy = 1; e_ov = 0; e_ra = m_base[i] + 10'(p - 1); do_rows = 0;
         end else if (p <= h + l) begin
            e_bsy = 1; e_ov = 0; e_ra = m_base[i] + 10'(h - 1); do_rows = 0;
         end else begin
            e_bsy = 0; e_ov = 1; e_ra = m_base[i] + 10'(h - 1); do_rows = 1; e_rows = m_exp[i];
         end
      end
      chk({pf, "_req_ready"}, 128'(rdy), 128'(e_rdy));
      chk({pf, "_out_valid"}, 128'(ov), 128'(e_ov));
      chk({pf, "_busy"}, 128'(bsy), 128'(e_bsy));
      chk({pf, "_rom_addr"}, 128'(ra), 128'(e_ra));
      if (do_rows) chk({pf, "_out_rows"}, rows, e_rows);
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (chk_en) begin
            check_inst(0, a_req_ready, a_out_valid, a_busy, a_rom_addr, {64'h0, a_out_rows});
            check_inst(1, b_req_ready, b_out_valid, b_busy, b_rom_addr, b_out_rows);
         end
         model_step(0, reset, a_req_valid, a_req_addr, a_req_mirror, a_out_ready);
         model_step(1, reset, b_req_valid, b_req_addr, b_req_mirror, b_out_ready);
         if (reset) chk_en = 1;
         cyc++;
      end
   end

   task automatic set_req(input int i, input logic v, input logic [9:0] ad, input logic m);
      if (i == 0) begin a_req_valid = v; a_req_addr = ad; a_req_mirror = m; end
      else begin b_req_valid = v; b_req_addr = ad; b_req_mirror = m; end
   endtask

   task automatic set_valid(input int i, input logic v);
      if (i == 0) a_req_valid = v; else b_req_valid = v;
   endtask

   task automatic set_ordy(input int i, input logic v);
      if (i == 0) a_out_ready = v; else b_out_ready = v;
   endtask

   function automatic logic get_rdy(input int i);
      return (i == 0) ? a_req_ready : b_req_ready;
   endfunction

   function automatic logic get_ov(input int i);
      return (i == 0) ? a_out_valid : b_out_valid;
   endfunction

   function automatic logic [9:0] get_ra(input int i);
      return (i == 0) ? a_rom_addr : b_rom_addr;
   endfunction

   task automatic accept_req(input int i, input logic [9:0] ad, input logic m, input bit early,
                             input bit keep);
      bit acc = 0;
      set_req(i, 1'b1, ad, m);
      if (early) set_ordy(i, 1'b1);
      for (int t = 0; t < 50 && !acc; t++) begin
         acc = get_rdy(i);
         @(posedge clock); #1;
      end
      chk("accept_timeout", 128'(acc), 128'(1));
      if (!keep) set_valid(i, 1'b0);
   endtask

   // Entered one cycle after acceptance; lat counts cycles from acceptance to out_valid.
   task automatic finish(input int i, input int hold, input bit keep, output int lat);
      int n = 1;
      while (!get_ov(i) && n < 100) begin
         if (n <= 16) seen_addr[n-1] = get_ra(i);
         @(posedge clock); #1;
         n++;
      end
      chk("out_valid_timeout", 128'(get_ov(i)), 128'(1));
      lat = n;
      repeat (hold) begin @(posedge clock); #1; end
      set_ordy(i, 1'b1);
      @(posedge clock); #1;
      set_ordy(i, 1'b0);
      if (keep) begin
         @(posedge clock); #1;
         set_valid(i, 1'b0);
      end
   endtask

   initial begin
      int lat;
      for (int n = 0; n < 1024; n++) mem[n] = 8'(n);
      for (int n = 32; n < 40; n++) mem[n] = 8'h01;
      wrap_exp = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003};
      reset = 1'b1;
      set_req(0, 1'b0, 10'h0, 1'b0);
      set_req(1, 1'b0, 10'h0, 1'b0);
      set_ordy(0, 1'b0);
      set_ordy(1, 1'b0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Identity ROM rows, plain order
      accept_req(0, 10'h010, 1'b0, 1'b0, 1'b0);
      finish(0, 0, 1'b0, lat);
      chk("t1_latency", 128'(lat), 128'(10));
      chk("t1_rows", {64'h0, a_out_rows}, 128'h1716151413121110);

      // Mirrored rows
      accept_req(0, 10'h020, 1'b1, 1'b0, 1'b0);
      finish(0, 2, 1'b0, lat);
      chk("t2_rows", {64'h0, a_out_rows}, 128'h8080808080808080);

      // Address wrap past top of ROM, out_ready asserted early
      accept_req(0, 10'h3FC, 1'b0, 1'b1, 1'b0);
      finish(0, 0, 1'b0, lat);
      for (int r = 0; r < 8; r++) chk($sformatf("t3_addr_%0d", r), 128'(seen_addr[r]), 128'(wrap_exp[r]));
      chk("t3_rows", {64'h0, a_out_rows}, 128'h03020100FFFEFDFC);

      // Backpressure with req_valid held high, then the queued request
      accept_req(0, 10'h010, 1'b0, 1'b0, 1'b1);
      finish(0, 20, 1'b1, lat);
      chk("t4_busy_after_reaccept", 128'(a_busy), 128'(1));
      finish(0, 0, 1'b0, lat);
      chk("t4_latency", 128'(lat), 128'(10));

      // Reset in cycle k+4
      accept_req(0, 10'h010, 1'b0, 1'b0, 1'b0);
      repeat (3) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("t5_req_ready", 128'(a_req_ready), 128'(1));
      chk("t5_out_valid", 128'(a_out_valid), 128'(0));
      chk("t5_busy", 128'(a_busy), 128'(0));
      chk("t5_rom_addr", 128'(a_rom_addr), 128'(0));
      chk("t5_rows", {64'h0, a_out_rows}, 128'h0);
      repeat (12) begin @(posedge clock); #1; end
      accept_req(0, 10'h030, 1'b1, 1'b0, 1'b0);
      finish(0, 0, 1'b0, lat);
      chk("t5_rows_after", {64'h0, a_out_rows}, 128'hEC6CAC2CCC4C8C0C);

      // Latency-2, 16-row build
      accept_req(1, 10'h100, 1'b0, 1'b0, 1'b0);
      finish(1, 3, 1'b0, lat);
      chk("t6_latency", 128'(lat), 128'(19));
      chk("t6_rows", b_out_rows, 128'h0F0E0D0C0B0A09080706050403020100);
      accept_req(1, 10'h3F8, 1'b1, 1'b1, 1'b0);
      finish(1, 0, 1'b0, lat);

      repeat (3) begin @(posedge clock); #1; end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
